// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: folds N consecutive PE products into one psum
// and holds it on a registered valid/ready port until the consumer takes it.
module psum_accumulator #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int NUM_OF_CHANNEL = 1,
  parameter int KERNEL_SIZE    = 3,
  parameter int PSUM_BITWIDTH  = 2*DATA_BITWIDTH+4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       wxi_valid,
  input  logic [2*DATA_BITWIDTH-1:0] wxi,
  output logic                       wxi_ready,
  output logic                       psum_valid,
  output logic [PSUM_BITWIDTH-1:0]   psum,
  input  logic                       psum_ready,
  output logic                       psum_ovf
);

  localparam int N  = NUM_OF_CHANNEL*KERNEL_SIZE;
  localparam int PW = PSUM_BITWIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   psum_q, psum_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;
  logic            term;
  logic            out_hs;
  logic            last;
  logic [PW:0]     sum;

  // acc and cnt are both zero in HOLD, so a term taken there
  // goes through the same add/last path as in ACC.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    psum_d    = psum_q;
    vld_d     = vld_q;
    ovf_d     = ovf_q;
    wxi_ready = 1'b0;
    unique case (state_q)
      ACC:  wxi_ready = en;
      HOLD: wxi_ready = en & psum_ready;
      default: wxi_ready = 1'b0;
    endcase
    term   = wxi_valid & wxi_ready;
    out_hs = vld_q & psum_ready;
    sum    = {1'b0, acc_q} + (PW+1)'(wxi);
    last   = (cnt_q == CW'(N-1));
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      vld_d   = 1'b0;
      ovf_d   = 1'b0;
      state_d = ACC;
    end else begin
      if (out_hs) begin
        vld_d   = 1'b0;
        state_d = ACC;
      end
      if (term) begin
        ovf_d = ovf_q | sum[PW];
        if (last) begin
          psum_d  = sum[PW-1:0];
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          acc_d = sum[PW-1:0];
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      psum_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign psum_valid = vld_q;
  assign psum       = psum_q;
  assign psum_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: 20-bit and 17-bit instances on shared
// stimulus, checked against an unwrapped-total reference model.
module tb_psum_accumulator;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en;
  logic        clear;
  logic        wxi_valid;
  logic [15:0] wxi;
  logic        psum_ready;

  logic        rdy_a, vld_a, ovf_a;
  logic [19:0] psum_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [16:0] psum_b;

  int n_chk  = 0;
  int n_fail = 0;

  bit              m_hold;
  int              m_n;
  longint unsigned m_total;
  logic [31:0]     m_psum_a, m_psum_b;
  bit              m_ovf_a, m_ovf_b;

  always #5 clk = ~clk;

  psum_accumulator u_a (
    .clk(clk), .rstN(rstN), .en(en), .clear(clear),
    .wxi_valid(wxi_valid), .wxi(wxi), .wxi_ready(rdy_a),
    .psum_valid(vld_a), .psum(psum_a),
    .psum_ready(psum_ready), .psum_ovf(ovf_a)
  );

  psum_accumulator #(.PSUM_BITWIDTH(17)) u_b (
    .clk(clk), .rstN(rstN), .en(en), .clear(clear),
    .wxi_valid(wxi_valid), .wxi(wxi), .wxi_ready(rdy_b),
    .psum_valid(vld_b), .psum(psum_b),
    .psum_ready(psum_ready), .psum_ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold   = 0;
    m_n      = 0;
    m_total  = 0;
    m_psum_a = 0;
    m_psum_b = 0;
    m_ovf_a  = 0;
    m_ovf_b  = 0;
  endtask

  // Sum is kept unwrapped; overflow means the running total reached 2^W.
  task automatic model_clock();
    bit term;
    term = wxi_valid & en & (!m_hold | psum_ready);
    if (clear) begin
      m_n     = 0;
      m_total = 0;
      m_hold  = 0;
      m_ovf_a = 0;
      m_ovf_b = 0;
    end else begin
      if (m_hold && psum_ready) m_hold = 0;
      if (term) begin
        m_total += 64'(wxi);
        m_n++;
        if (m_total >= (64'd1 << 20)) m_ovf_a = 1;
        if (m_total >= (64'd1 << 17)) m_ovf_b = 1;
        if (m_n == N) begin
          m_psum_a = 32'(m_total % (64'd1 << 20));
          m_psum_b = 32'(m_total % (64'd1 << 17));
          m_hold   = 1;
          m_total  = 0;
          m_n      = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] er;
    er = 32'(en & (!m_hold | psum_ready));
    chk("rdy_a", 32'(rdy_a), er);
    chk("rdy_b", 32'(rdy_b), er);
    chk("vld_a", 32'(vld_a), 32'(m_hold));
    chk("vld_b", 32'(vld_b), 32'(m_hold));
    chk("psum_a", 32'(psum_a), m_psum_a);
    chk("psum_b", 32'(psum_b), m_psum_b);
    chk("ovf_a", 32'(ovf_a), 32'(m_ovf_a));
    chk("ovf_b", 32'(ovf_b), 32'(m_ovf_b));
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic put(input bit v, input logic [15:0] w, input bit e = 1,
                     input bit pr = 1, input bit c = 0);
    wxi_valid  = v;
    wxi        = w;
    en         = e;
    psum_ready = pr;
    clear      = c;
    step();
  endtask

  task automatic do_reset();
    #2;
    rstN = 1'b0;
    model_reset();
    #1;
    chk("rst_vld", 32'(vld_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_psum", 32'(psum_a), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    rstN       = 1'b0;
    en         = 1'b0;
    clear      = 1'b0;
    wxi_valid  = 1'b0;
    wxi        = '0;
    psum_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("init_vld", 32'(vld_a), 0);
    chk("init_psum", 32'(psum_a), 0);
    chk("init_ovf", 32'(ovf_b), 0);
    rstN = 1'b1;

    put(1, 10); put(1, 20);
    do_reset();
    put(1, 1); put(1, 2); put(1, 3);
    chk("rst_sum", 32'(psum_a), 6);
    put(0, 0);

    put(1, 10); put(1, 20); put(1, 30);
    chk("basic_sum", 32'(psum_a), 60);
    chk("basic_vld", 32'(vld_a), 1);
    put(1, 1);
    chk("basic_pulse", 32'(vld_a), 0);
    put(1, 1); put(1, 1);
    chk("b2b_sum", 32'(psum_a), 3);
    put(0, 0);

    put(1, 10); put(1, 20); put(1, 30, 1, 0);
    for (int i = 0; i < 5; i++) begin
      put(1, 9, 1, 0);
      chk("bp_rdy", 32'(rdy_a), 0);
      chk("bp_psum", 32'(psum_a), 60);
    end
    put(1, 5, 1, 1);
    chk("bp_release", 32'(vld_a), 0);
    put(1, 7); put(1, 8);
    chk("bp_sum", 32'(psum_a), 20);
    put(0, 0);

    put(1, 65025); put(1, 65025); put(1, 65025);
    chk("w20_sum", 32'(psum_a), 195075);
    chk("w20_ovf", 32'(ovf_a), 0);
    chk("w17_sum", 32'(psum_b), 64003);
    chk("w17_ovf", 32'(ovf_b), 1);
    put(1, 1); put(1, 2); put(1, 3);
    chk("w17_sum2", 32'(psum_b), 6);
    chk("w17_sticky", 32'(ovf_b), 1);
    put(0, 0, 1, 1, 1);
    chk("w17_clr", 32'(ovf_b), 0);

    put(1, 4);
    for (int i = 0; i < 3; i++) begin
      put(1, 9, 0);
      chk("en_rdy", 32'(rdy_a), 0);
    end
    put(1, 5); put(1, 6);
    chk("en_sum", 32'(psum_a), 15);
    put(0, 0);

    put(1, 100); put(1, 200);
    put(0, 0, 1, 1, 1);
    put(1, 1); put(1, 2); put(1, 3);
    chk("clr_sum", 32'(psum_a), 6);
    put(1, 1); put(1, 1); put(1, 1, 1, 0);
    chk("clr_hold", 32'(vld_a), 1);
    put(0, 0, 1, 0, 1);
    chk("clr_drop", 32'(vld_a), 0);
    chk("clr_keep", 32'(psum_a), 3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      put(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 63) == 0));
    end
    put(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
